// File: rtl/bcd_key_entry.sv
// Operator entry stage: debounces a push-button, validates two BCD switch
// digits on each press, latches them and hands one start pulse to bcd2bin,
// then stays busy until the compute chain reports done.
module bcd_key_entry #(
  parameter int DB_TICKS = 1_000_000,
  parameter int MAX_N    = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] sw,
  input  logic       btn,
  input  logic       ready_in,
  input  logic       done_in,
  output logic [3:0] bcd1,
  output logic [3:0] bcd0,
  output logic       start,
  output logic       busy,
  output logic       err
);

  localparam int             CW       = $clog2(DB_TICKS);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DB_TICKS - 1);
  localparam logic [7:0]     MAX_V    = 8'(MAX_N);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;

  state_t        state, state_nx;
  logic          s1, s;
  logic          db, db_q;
  logic [CW-1:0] cnt;
  logic          press, valid;
  logic [7:0]    entry_val;
  logic          load, set_err, issue;

  // Two-flop synchronizer for the asynchronous button.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s  <= 1'b0;
    end else begin
      s1 <= btn;
      s  <= s1;
    end
  end

  // Debounce: db follows s only after DB_TICKS consecutive differing samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      db  <= 1'b0;
    end else if (s == db) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      db  <= s;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Delayed debounced level for rising-edge detection.
  always_ff @(posedge clk) begin
    if (reset) db_q <= 1'b0;
    else       db_q <= db;
  end

  assign press     = db & ~db_q;
  // Worst case 15*10+15 = 165 still fits 8 bits, so no overflow on bad digits.
  assign entry_val = {4'd0, sw[7:4]} * 8'd10 + {4'd0, sw[3:0]};
  assign valid     = (sw[7:4] <= 4'd9) && (sw[3:0] <= 4'd9) && (entry_val <= MAX_V);
  assign busy      = (state != IDLE);

  // Next-state and per-cycle control decode.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    set_err  = 1'b0;
    issue    = 1'b0;
    case (state)
      IDLE: begin
        if (press) begin
          if (valid) begin
            load     = 1'b1;
            state_nx = ISSUE;
          end else begin
            set_err  = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (ready_in) begin
          issue    = 1'b1;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        if (done_in) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, registered start pulse, latched digits and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      start <= 1'b0;
      bcd1  <= 4'd0;
      bcd0  <= 4'd0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      start <= issue;
      if (load) begin
        bcd1 <= sw[7:4];
        bcd0 <= sw[3:0];
        err  <= 1'b0;
      end else if (set_err) begin
        err  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bcd_key_entry.sv
// Bench for bcd_key_entry: directed scenarios plus a random soak, every cycle
// checked against a behavioural model of the entry rules.
module tb_bcd_key_entry;

  localparam int DB    = 4;
  localparam int MAXN  = 30;
  localparam int M_IDLE = 0, M_ISSUE = 1, M_BUSY = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] sw = 8'h00;
  logic       btn = 1'b0, ready_in = 1'b0, done_in = 1'b0;
  logic [3:0] bcd1, bcd0;
  logic       start, busy, err;

  int tests = 0, failed = 0;
  int edge_n = 0, starts = 0, last_start = -1;

  // reference model state
  int m_mode = M_IDLE;
  int m_bcd1 = 0, m_bcd0 = 0, m_err = 0, m_start = 0;
  int m_hist[$];          // raw btn samples, newest at back
  int m_s1 = 0, m_s = 0, m_db = 0, m_dbq = 0, m_run = 0;

  bcd_key_entry #(.DB_TICKS(DB), .MAX_N(MAXN)) dut (
    .clk(clk), .reset(reset), .sw(sw), .btn(btn), .ready_in(ready_in),
    .done_in(done_in), .bcd1(bcd1), .bcd0(bcd0), .start(start),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int model_press();
    return (m_db == 1 && m_dbq == 0) ? 1 : 0;
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_edge();
    int t, u, ok, nstart;
    if (reset) begin
      m_mode = M_IDLE; m_bcd1 = 0; m_bcd0 = 0; m_err = 0; m_start = 0;
      m_s1 = 0; m_s = 0; m_db = 0; m_dbq = 0; m_run = 0;
      return;
    end
    t  = int'(sw[7:4]);
    u  = int'(sw[3:0]);
    ok = (t <= 9 && u <= 9 && 10 * t + u <= MAXN) ? 1 : 0;
    nstart = (m_mode == M_ISSUE && ready_in) ? 1 : 0;
    if (m_mode == M_IDLE && model_press() == 1) begin
      if (ok == 1) begin m_bcd1 = t; m_bcd0 = u; m_err = 0; m_mode = M_ISSUE; end
      else m_err = 1;
    end else if (m_mode == M_ISSUE && ready_in) m_mode = M_BUSY;
    else if (m_mode == M_BUSY && done_in) m_mode = M_IDLE;
    m_start = nstart;
    // debounced level flips after DB consecutive disagreeing synced samples
    m_dbq = m_db;
    if (m_s != m_db) begin
      m_run++;
      if (m_run == DB) begin m_db = m_s; m_run = 0; end
    end else m_run = 0;
    m_s  = m_s1;
    m_s1 = int'(btn);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    edge_n++;
    #1;
    chk("start", int'(start), m_start);
    chk("busy",  int'(busy),  (m_mode != M_IDLE) ? 1 : 0);
    chk("bcd1",  int'(bcd1),  m_bcd1);
    chk("bcd0",  int'(bcd0),  m_bcd0);
    chk("err",   int'(err),   m_err);
    if (start) begin starts++; last_start = edge_n; end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    reset = 1'b1; steps(2); reset = 1'b0;
  endtask

  task automatic pulse_done();
    done_in = 1'b1; step(); done_in = 1'b0;
  endtask

  initial begin
    int k0, s0, bound;

    // Reset state
    do_reset();
    chk("rst_start", int'(start), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_bcd", int'({bcd1, bcd0}), 0);

    // 1: basic press, latency and busy span
    sw = 8'h21; ready_in = 1'b1;
    k0 = edge_n; s0 = starts;
    btn = 1'b1; steps(20); btn = 1'b0;
    chk("t1_starts", starts - s0, 1);
    chk("t1_latency", last_start - k0, DB + 4);
    chk("t1_bcd1", int'(bcd1), 2);
    chk("t1_bcd0", int'(bcd0), 1);
    chk("t1_busy", int'(busy), 1);
    steps(10);
    chk("t1_busy_wait", int'(busy), 1);
    pulse_done();
    chk("t1_idle", int'(busy), 0);

    // 2: bounce shorter than debounce window
    steps(10);
    s0 = starts;
    for (int i = 0; i < 15; i++) begin btn = ~btn; steps(2); end
    btn = 1'b0; steps(12);
    chk("t2_starts", starts - s0, 0);
    chk("t2_err", int'(err), 0);
    chk("t2_busy", int'(busy), 0);

    // 3: invalid entries
    do_reset();
    s0 = starts;
    sw = 8'h3A; btn = 1'b1; steps(12); btn = 1'b0; steps(12);
    chk("t3a_err", int'(err), 1);
    sw = 8'h31; btn = 1'b1; steps(12); btn = 1'b0; steps(12);
    chk("t3b_err", int'(err), 1);
    chk("t3_starts", starts - s0, 0);
    chk("t3_bcd", int'({bcd1, bcd0}), 0);

    // 4: downstream not ready
    sw = 8'h05; ready_in = 1'b0; s0 = starts;
    btn = 1'b1; steps(12); btn = 1'b0; steps(38);
    chk("t4_hold_starts", starts - s0, 0);
    chk("t4_hold_busy", int'(busy), 1);
    chk("t4_err_clr", int'(err), 0);
    ready_in = 1'b1; k0 = edge_n;
    steps(5);
    chk("t4_starts", starts - s0, 1);
    chk("t4_latency", last_start - k0, 1);
    pulse_done();

    // 5: press coincident with done_in is dropped
    sw = 8'h12; s0 = starts;
    btn = 1'b1; steps(12); btn = 1'b0; steps(10);
    chk("t5_first", starts - s0, 1);
    sw = 8'h29; btn = 1'b1;
    bound = 0;
    while (model_press() == 0 && bound < 30) begin step(); bound++; end
    chk("t5_press_seen", model_press(), 1);
    done_in = 1'b1; step(); done_in = 1'b0;
    btn = 1'b0; steps(15);
    chk("t5_no_second", starts - s0, 1);
    chk("t5_idle", int'(busy), 0);
    chk("t5_bcd", int'({bcd1, bcd0}), 8'h12);
    sw = 8'h07; btn = 1'b1; steps(12); btn = 1'b0; steps(5);
    chk("t5_later", starts - s0, 2);
    chk("t5_later_bcd", int'({bcd1, bcd0}), 8'h07);
    pulse_done();

    // 6: reset while waiting in ISSUE, button held across it
    steps(8);
    sw = 8'h09; ready_in = 1'b0; btn = 1'b1; steps(12);
    chk("t6_issue", int'(busy), 1);
    do_reset();
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_bcd", int'({bcd1, bcd0}), 0);
    chk("t6_rst_start", int'(start), 0);
    k0 = edge_n; s0 = starts; ready_in = 1'b1;
    steps(12);
    chk("t6_starts", starts - s0, 1);
    chk("t6_latency", last_start - k0, DB + 4);
    btn = 1'b0; pulse_done(); steps(10);

    // Random soak against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) btn = ~btn;
      ready_in = ($urandom_range(0, 3) != 0);
      done_in  = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 19) == 0)
        sw = ($urandom_range(0, 1) == 0) ? 8'($urandom) :
             {4'($urandom_range(0, 3)), 4'($urandom_range(0, 9))};
      if ($urandom_range(0, 499) == 0) reset = 1'b1;
      step();
      reset = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
